// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one adder row reused over N_BITS cycles.
// Signed operands are multiplied as magnitudes, and the sign is applied in a final FIX cycle.
module seq_multiplier #(
    parameter int N_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [N_BITS-1:0]     a,
    input  logic [N_BITS-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product
);

    localparam int CW = $clog2(N_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                state_q;
    logic [N_BITS-1:0]     mcand_q;
    logic [N_BITS-1:0]     mplier_q;
    logic [N_BITS-1:0]     acc_hi_q;
    logic [N_BITS-1:0]     acc_lo_q;
    logic [CW-1:0]         count_q;
    logic                  neg_q;
    logic                  busy_q;
    logic                  done_q;
    logic [2*N_BITS-1:0]   product_q;

    logic [N_BITS-1:0]     a_mag_d;
    logic [N_BITS-1:0]     b_mag_d;
    logic                  neg_d;
    logic [N_BITS:0]       row_d;
    logic [2*N_BITS-1:0]   acc_d;

    // |-2^(N-1)| wraps to 2^(N-1), which is still correct when read as unsigned.
    always_comb begin
        a_mag_d = (signed_mode && a[N_BITS-1]) ? (N_BITS'(0) - a) : a;
        b_mag_d = (signed_mode && b[N_BITS-1]) ? (N_BITS'(0) - b) : b;
        neg_d   = signed_mode & (a[N_BITS-1] ^ b[N_BITS-1]);
        row_d   = {1'b0, acc_hi_q} + {1'b0, mcand_q & {N_BITS{mplier_q[0]}}};
        acc_d   = {acc_hi_q, acc_lo_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q  <= a_mag_d;
                        mplier_q <= b_mag_d;
                        neg_q    <= neg_d;
                        acc_hi_q <= '0;
                        acc_lo_q <= '0;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    // Carry-out of the row becomes the new MSB as {row, acc_lo} shifts right.
                    acc_hi_q <= row_d[N_BITS:1];
                    acc_lo_q <= {row_d[0], acc_lo_q[N_BITS-1:1]};
                    mplier_q <= mplier_q >> 1;
                    count_q  <= count_q + CW'(1);
                    if (count_q == CW'(N_BITS - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    product_q <= neg_q ? ((2*N_BITS)'(0) - acc_d) : acc_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (N_BITS=4): directed cases, random ops
// with optional back-to-back starts, and a full sweep against an arithmetic model.
module tb_seq_multiplier;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           signed_mode;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int             n_checks = 0;
    int             n_pass   = 0;
    logic [2*N-1:0] last_exp = '0;

    seq_multiplier #(.N_BITS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic on the operands as interpreted by the mode.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                                               input logic sm);
        int xi;
        int yi;
        xi = int'(x);
        yi = int'(y);
        if (sm && x[N-1]) xi = xi - (1 << N);
        if (sm && y[N-1]) yi = yi - (1 << N);
        return (2*N)'(xi * yi);
    endfunction

    // Called at a negedge: present a request for one edge, return at the next negedge.
    task automatic issue(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic sm);
        start       = 1'b1;
        a           = ta;
        b           = tb_v;
        signed_mode = sm;
        @(negedge clk);
        start       = 1'b0;
        a           = $urandom_range(0, (1 << N) - 1);
        b           = $urandom_range(0, (1 << N) - 1);
        signed_mode = 1'($urandom_range(0, 1));
    endtask

    // start_cyc = number of negedges already seen since the accept edge.
    task automatic wait_done(input string tag, input int start_cyc, input logic [2*N-1:0] exp);
        int             cyc = start_cyc;
        int             busy_cnt = 0;
        logic           stable = 1'b1;
        logic [2*N-1:0] p0 = product;
        while (!done && cyc < 40) begin
            if (busy) busy_cnt++;
            if (product !== p0) stable = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check({tag, " done"}, 64'(done), 64'(1));
        check({tag, " latency"}, 64'(cyc), 64'(N + 2));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(N + 2 - start_cyc));
        check({tag, " busy_at_done"}, 64'(busy), 64'(0));
        check({tag, " hold"}, 64'(stable), 64'(1));
        check({tag, " product"}, 64'(product), 64'(exp));
        last_exp = exp;
    endtask

    // Assumes the previous call left us at its done-cycle negedge.
    task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                          input logic sm, input logic b2b, input logic [2*N-1:0] exp);
        if (!b2b) begin
            @(negedge clk);
            check({tag, " done_width"}, 64'(done), 64'(0));
            check({tag, " idle_hold"}, 64'(product), 64'(last_exp));
        end
        issue(ta, tb_v, sm);
        wait_done(tag, 1, exp);
    endtask

    initial begin
        int             done_seen;
        logic [N-1:0]   ra;
        logic [N-1:0]   rb;
        logic           rs;

        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        #23;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op("u15x15", 4'hF, 4'hF, 1'b0, 1'b0, 8'hE1);
        run_op("s-8x-8", 4'h8, 4'h8, 1'b1, 1'b0, 8'h40);
        run_op("s-3x5",  4'hD, 4'h5, 1'b1, 1'b0, 8'hF1);
        run_op("s0x-7",  4'h0, 4'h9, 1'b1, 1'b0, 8'h00);
        run_op("u8x2",   4'h8, 4'h2, 1'b0, 1'b0, 8'h10);

        // Second request arrives while busy and must be dropped.
        @(negedge clk);
        issue(4'h3, 4'h3, 1'b0);
        start = 1'b1;
        a     = 4'h7;
        b     = 4'h7;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_drop", 2, 8'h09);
        run_op("b2b 2x6", 4'h2, 4'h6, 1'b0, 1'b1, 8'h0C);

        // Asynchronous reset between edges during CALC.
        @(negedge clk);
        issue(4'h9, 4'h9, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst busy", 64'(busy), 64'(0));
        check("async_rst done", 64'(done), 64'(0));
        check("async_rst product", 64'(product), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("post_rst no_done", 64'(done_seen), 64'(0));
        last_exp = '0;
        run_op("u9x9", 4'h9, 4'h9, 1'b0, 1'b0, 8'h51);

        for (int i = 0; i < 120; i++) begin
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = N'($urandom_range(0, (1 << N) - 1));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d %0h*%0h s%0d", i, ra, rb, rs), ra, rb, rs,
                   1'($urandom_range(0, 1)), ref_mul(ra, rb, rs));
        end

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < (1 << N); i++) begin
                for (int j = 0; j < (1 << N); j++) begin
                    run_op($sformatf("sweep %0h*%0h s%0d", i, j, m), N'(i), N'(j), 1'(m),
                           1'b0, ref_mul(N'(i), N'(j), 1'(m)));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
